// File: rtl/speech_capture.sv
// Decimating voice-activity capture: averages codec samples, measures frame energy, and buffers an utterance.
// Optional DC-blocking high-pass between decimator and magnitude when SPEECH_CAPTURE_DC_BLOCK_EN is defined.
module speech_capture #(
    parameter int DECIM      = 4,
    parameter int FRAME_LEN  = 64,
    parameter int THRESH     = 600,
    parameter int SIL_FRAMES = 8,
    parameter int ADDR_W     = 12
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [15:0]       ain,
    input  logic              ain_new,
    input  logic              start,
    input  logic              ack,
    output logic              armed,
    output logic              capturing,
    output logic              done,
    output logic [ADDR_W:0]   cap_len,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [15:0]       rd_data,
    output logic [14:0]       level,
    output logic              level_valid,
    output logic [1:0]        state_dbg
);
    localparam int LOG_D = $clog2(DECIM);
    localparam int LOG_F = $clog2(FRAME_LEN);
    localparam int DCW   = (LOG_D > 0) ? LOG_D : 1;
    localparam int ESW   = 15 + LOG_F;
    localparam int CLW   = ADDR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;
    state_t state_q, state_d;

    // Decimator: block average of DECIM strobes, runs in every state.
    logic signed [19:0] acc, acc_sum, acc_shr;
    logic [DCW-1:0]     dcnt;
    logic signed [15:0] dec;
    logic               dec_v;

    assign acc_sum = acc + {{4{ain[15]}}, ain};
    assign acc_shr = acc_sum >>> LOG_D;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            acc   <= '0;
            dcnt  <= '0;
            dec   <= '0;
            dec_v <= 1'b0;
        end else begin
            dec_v <= 1'b0;
            if (ain_new) begin
                if (dcnt == DCW'(DECIM - 1)) begin
                    dec   <= acc_shr[15:0];
                    dec_v <= 1'b1;
                    acc   <= '0;
                    dcnt  <= '0;
                end else begin
                    acc  <= acc_sum;
                    dcnt <= dcnt + DCW'(1);
                end
            end
        end
    end

    logic signed [15:0] smp;
    logic               smp_v;

`ifdef SPEECH_CAPTURE_DC_BLOCK_EN
    logic signed [15:0] dec_prev, filt;
    logic signed [17:0] y_prev, y_sat;
    logic signed [19:0] y_full;
    logic               filt_v;

    assign y_full = {{4{dec[15]}}, dec} - {{4{dec_prev[15]}}, dec_prev}
                  + {{2{y_prev[17]}}, y_prev} - {{2{y_prev[17]}}, (y_prev >>> 6)};

    always_comb begin
        y_sat = y_full[17:0];
        if (y_full > 20'sd131071)       y_sat = 18'sh1FFFF;
        else if (y_full < -20'sd131072) y_sat = 18'sh20000;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            dec_prev <= '0;
            y_prev   <= '0;
            filt     <= '0;
            filt_v   <= 1'b0;
        end else begin
            filt_v <= dec_v;
            if (dec_v) begin
                dec_prev <= dec;
                y_prev   <= y_sat;
                if (y_sat > 18'sd32767)       filt <= 16'sh7FFF;
                else if (y_sat < -18'sd32768) filt <= 16'sh8000;
                else                          filt <= y_sat[15:0];
            end
        end
    end

    assign smp   = filt;
    assign smp_v = filt_v;
`else
    assign smp   = dec;
    assign smp_v = dec_v;
`endif

    // Magnitude with -32768 folded onto the largest positive value.
    logic signed [15:0] neg;
    logic [14:0]        mag;
    assign neg = -smp;

    always_comb begin
        mag = smp[14:0];
        if (smp == 16'sh8000) mag = 15'h7FFF;
        else if (smp[15])     mag = neg[14:0];
    end

    logic [ESW-1:0]   esum, esum_next;
    logic [LOG_F-1:0] fcnt;
    logic [14:0]      new_level;
    logic             frame_end, loud;

    assign esum_next = esum + ESW'(mag);
    assign new_level = esum_next[LOG_F +: 15];
    assign frame_end = smp_v && (fcnt == LOG_F'(FRAME_LEN - 1));
    assign loud      = (new_level >= 15'(THRESH));

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            esum        <= '0;
            fcnt        <= '0;
            level       <= '0;
            level_valid <= 1'b0;
        end else begin
            level_valid <= 1'b0;
            if (smp_v) begin
                if (frame_end) begin
                    level       <= new_level;
                    level_valid <= 1'b1;
                    esum        <= '0;
                    fcnt        <= '0;
                end else begin
                    esum <= esum_next;
                    fcnt <= fcnt + LOG_F'(1);
                end
            end
        end
    end

    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        quiet_cnt;
    logic              wr_en, cap_exit;

    // The write of a sample coinciding with a frame end counts toward cap_len.
    always_comb begin
        state_d  = state_q;
        wr_en    = 1'b0;
        cap_exit = 1'b0;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ARMED;
            S_ARMED: if (frame_end && loud) state_d = S_CAPTURE;
            S_CAPTURE: begin
                if (smp_v) begin
                    wr_en = 1'b1;
                    if (&wr_addr) cap_exit = 1'b1;
                    else if (frame_end && !loud && quiet_cnt == 8'(SIL_FRAMES - 1)) cap_exit = 1'b1;
                end
                if (cap_exit) state_d = S_DONE;
            end
            S_DONE:  if (ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= S_IDLE;
            armed     <= 1'b0;
            capturing <= 1'b0;
            done      <= 1'b0;
            wr_addr   <= '0;
            quiet_cnt <= '0;
            cap_len   <= '0;
        end else begin
            state_q   <= state_d;
            armed     <= (state_d == S_ARMED);
            capturing <= (state_d == S_CAPTURE);
            done      <= (state_d == S_DONE);
            if (state_q == S_IDLE && start) begin
                wr_addr   <= '0;
                quiet_cnt <= '0;
            end
            if (wr_en) wr_addr <= wr_addr + ADDR_W'(1);
            if (state_q == S_CAPTURE && frame_end) quiet_cnt <= loud ? 8'd0 : quiet_cnt + 8'd1;
            if (cap_exit) cap_len <= {1'b0, wr_addr} + CLW'(1);
        end
    end

    assign state_dbg = state_q;

    logic [15:0] mem [2**ADDR_W];

    always_ff @(posedge CLOCK_50) begin
        if (wr_en && !reset) mem[wr_addr] <= smp;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) rd_data <= '0;
        else       rd_data <= mem[rd_addr];
    end
endmodule
